// File: rtl/cam_stream_pkg.sv
// Shared types and helpers for the camera stream arbiter: FSM states, word classes,
// SOF/EOF patch-number codes and a ceil-log2 used for index widths.
package cam_stream_pkg;

  typedef enum logic [1:0] {
    INTERFRAME = 2'd0,
    INTRAFRAME = 2'd1,
    ERROR      = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WC_SOF  = 2'd0,
    WC_EOF  = 2'd1,
    WC_DATA = 2'd2,
    WC_BAD  = 2'd3
  } wclass_e;

  // SOF is the all-ones patch number, EOF the one just below it.
  function automatic logic [31:0] sof_code(input int pn_size);
    return 32'((64'd1 << pn_size) - 64'd1);
  endfunction

  function automatic logic [31:0] eof_code(input int pn_size);
    return sof_code(pn_size) - 32'd1;
  endfunction

  function automatic int log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cam_stream_arbiter_if.sv
// Camera FIFO read ports plus the merged output stream. The slave modport is the
// arbiter's view; the master modport is the FIFO/downstream side.
interface cam_stream_arbiter_if #(
  parameter int N_CAM   = 3,
  parameter int PN_SIZE = 20,
  parameter int FP_SIZE = 20
) ();
  import cam_stream_pkg::*;

  localparam int W     = PN_SIZE + FP_SIZE;
  localparam int CAM_W = log2(N_CAM);

  logic [N_CAM-1:0]   input_val;
  logic [N_CAM*W-1:0] input_data;
  logic [N_CAM-1:0]   input_ack;
  logic               out_val;
  logic               out_rdy;
  logic [W-1:0]       out_data;
  logic [CAM_W-1:0]   out_cam;

  modport master (
    output input_val, input_data, out_rdy,
    input  input_ack, out_val, out_data, out_cam
  );

  modport slave (
    input  input_val, input_data, out_rdy,
    output input_ack, out_val, out_data, out_cam
  );

endinterface

// File: rtl/stream_rr_pick.sv
// Combinational rotate-priority picker: the first requester after 'last' (mod N_CAM)
// wins; returns a one-hot grant and its index (all zero when nobody requests).
module stream_rr_pick
  import cam_stream_pkg::*;
#(
  parameter int N_CAM = 3,
  parameter int CAM_W = log2(N_CAM)
) (
  input  logic [N_CAM-1:0] req,
  input  logic [CAM_W-1:0] last,
  output logic [N_CAM-1:0] gnt,
  output logic [CAM_W-1:0] gnt_idx
);

  logic [CAM_W:0] pos;
  logic           found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int i = 1; i <= N_CAM; i++) begin
      pos = {1'b0, last} + (CAM_W+1)'(i);
      if (pos >= (CAM_W+1)'(N_CAM)) pos = pos - (CAM_W+1)'(N_CAM);
      if (!found && req[pos[CAM_W-1:0]]) begin
        found                 = 1'b1;
        gnt_idx               = pos[CAM_W-1:0];
        gnt[pos[CAM_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_stream_arbiter.sv
// Frame-aligned round-robin merge of N_CAM camera FIFOs into one registered stream.
// Optional SOF-alignment watchdog is enabled by defining CAM_STREAM_ARB_TIMEOUT_EN.
module cam_stream_arbiter
  import cam_stream_pkg::*;
#(
  parameter int N_CAM   = 3,
  parameter int PN_SIZE = 20,
  parameter int FP_SIZE = 20,
  parameter int N_PATCH = 600000
`ifdef CAM_STREAM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 65535
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET,
  cam_stream_arbiter_if.slave   bus,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  error
);

  localparam int W     = PN_SIZE + FP_SIZE;
  localparam int CAM_W = log2(N_CAM);
  localparam logic [PN_SIZE-1:0] SOF_PN = PN_SIZE'(sof_code(PN_SIZE));
  localparam logic [PN_SIZE-1:0] EOF_PN = PN_SIZE'(eof_code(PN_SIZE));

  function automatic wclass_e classify(input logic [PN_SIZE-1:0] pn);
    if (pn == SOF_PN) return WC_SOF;
    if (pn == EOF_PN) return WC_EOF;
    if (32'(pn) < 32'(N_PATCH)) return WC_DATA;
    return WC_BAD;
  endfunction

  state_e             state, state_nx;
  logic [W-1:0]       head [N_CAM];
  logic [N_CAM-1:0]   sof_v, eof_v, data_v, bad_v;
  logic [N_CAM-1:0]   eof_seen, eof_nx, req, gnt, ack;
  logic [CAM_W-1:0]   rr_last, gnt_idx;
  logic               load_ok, load_word, start_nx, done_nx, wdog_hit;
  logic               vld_p1;
  logic [W-1:0]       out_data_p1;
  logic [CAM_W-1:0]   out_cam_p1;

  always_comb begin
    sof_v  = '0;
    eof_v  = '0;
    data_v = '0;
    bad_v  = '0;
    for (int c = 0; c < N_CAM; c++) begin
      head[c] = bus.input_data[c*W +: W];
      case (classify(head[c][W-1 -: PN_SIZE]))
        WC_SOF:  sof_v[c]  = bus.input_val[c];
        WC_EOF:  eof_v[c]  = bus.input_val[c];
        WC_DATA: data_v[c] = bus.input_val[c];
        default: bad_v[c]  = bus.input_val[c];
      endcase
    end
  end

  assign req     = data_v & ~eof_seen;
  assign load_ok = !vld_p1 || bus.out_rdy;

  stream_rr_pick #(.N_CAM(N_CAM), .CAM_W(CAM_W)) u_pick (
    .req     (req),
    .last    (rr_last),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef CAM_STREAM_ARB_TIMEOUT_EN
  logic [15:0] wdog_q;
  // Counts only while alignment is partial; full alignment (frame start) clears it.
  always_ff @(posedge CLK) begin
    if (RESET || state != INTERFRAME || !(|sof_v) || (&sof_v)) wdog_q <= '0;
    else if (!wdog_hit) wdog_q <= wdog_q + 16'd1;
  end
  assign wdog_hit = (state == INTERFRAME) && (wdog_q >= 16'(TIMEOUT));
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    ack       = '0;
    eof_nx    = eof_seen;
    start_nx  = 1'b0;
    done_nx   = 1'b0;
    load_word = 1'b0;
    case (state)
      INTERFRAME: begin
        if (|bad_v || wdog_hit) begin
          state_nx = ERROR;
        end else if (&sof_v) begin
          ack      = sof_v;
          start_nx = 1'b1;
          eof_nx   = '0;
          state_nx = INTRAFRAME;
        end else begin
          ack = data_v | eof_v;
        end
      end
      INTRAFRAME: begin
        if (|bad_v || |(sof_v & ~eof_seen)) begin
          state_nx = ERROR;
        end else begin
          // EOF retirement runs alongside the data grant; a cam's single head word
          // cannot be both, so the two ack sets never overlap.
          ack    = eof_v & ~eof_seen;
          eof_nx = eof_seen | eof_v;
          if (load_ok && |gnt) begin
            ack       = ack | gnt;
            load_word = 1'b1;
          end
          if (&eof_nx) begin
            done_nx  = 1'b1;
            state_nx = INTERFRAME;
          end
        end
      end
      ERROR:   state_nx = ERROR;
      default: state_nx = ERROR;
    endcase
  end

  assign bus.input_ack = ack;

  always_ff @(posedge CLK) begin
    if (RESET) state <= INTERFRAME;
    else       state <= state_nx;
  end

  // p0 -> p1: FIFO head captured into the output register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vld_p1      <= 1'b0;
      out_data_p1 <= '0;
      out_cam_p1  <= '0;
      rr_last     <= CAM_W'(N_CAM - 1);
      eof_seen    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      error       <= 1'b0;
    end else begin
      eof_seen    <= eof_nx;
      frame_start <= start_nx;
      frame_done  <= done_nx;
      if (done_nx) frame_cnt <= frame_cnt + 16'd1;
      if (state_nx == ERROR) begin
        error  <= 1'b1;
        vld_p1 <= 1'b0;
      end else if (load_ok) begin
        vld_p1 <= load_word;
      end
      if (load_word) begin
        out_data_p1 <= head[gnt_idx];
        out_cam_p1  <= gnt_idx;
        rr_last     <= gnt_idx;
      end
    end
  end

  assign bus.out_val  = vld_p1;
  assign bus.out_data = out_data_p1;
  assign bus.out_cam  = out_cam_p1;

endmodule

// File: tb/tb_cam_stream_arbiter.sv
// Directed bench for cam_stream_arbiter: FIFO models per camera, hand-computed
// grant order, backpressure, EOF handling, error cases and the SOF watchdog.
module tb_cam_stream_arbiter;

  localparam int W = 40;

  logic        clk;
  logic        RESET;
  logic        frame_start, frame_done, error;
  logic [15:0] frame_cnt;

  cam_stream_arbiter_if #(.N_CAM(3), .PN_SIZE(20), .FP_SIZE(20)) bus ();

`ifdef CAM_STREAM_ARB_TIMEOUT_EN
  cam_stream_arbiter #(.N_CAM(3), .PN_SIZE(20), .FP_SIZE(20), .N_PATCH(600000), .TIMEOUT(100)) dut (
`else
  cam_stream_arbiter #(.N_CAM(3), .PN_SIZE(20), .FP_SIZE(20), .N_PATCH(600000)) dut (
`endif
    .CLK         (clk),
    .RESET       (RESET),
    .bus         (bus),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] q0[$], q1[$], q2[$];
  logic [W-1:0] rx_data[$];
  int           rx_cam[$];
  int           rx_cyc[$];
  logic [2:0]   ack_s;
  int           n_tot, n_bad, cyc, n_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dw(input int c, input int k);
    return {20'(c*16 + k), 20'(32'h12340 + c*16 + k)};
  endfunction

  function automatic logic [W-1:0] sofw(input int c);
    return {20'hFFFFF, 20'(c)};
  endfunction

  function automatic logic [W-1:0] eofw(input int c);
    return {20'hFFFFE, 20'(c)};
  endfunction

  task automatic push(input int c, input logic [W-1:0] w);
    case (c)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic frame_words(input int c, input int nd);
    push(c, sofw(c));
    for (int k = 0; k < nd; k++) push(c, dw(c, k));
    push(c, eofw(c));
  endtask

  task automatic drive();
    logic [2:0]     v;
    logic [3*W-1:0] d;
    v = {q2.size() > 0, q1.size() > 0, q0.size() > 0};
    d = '0;
    if (q0.size() > 0) d[W-1:0]     = q0[0];
    if (q1.size() > 0) d[2*W-1:W]   = q1[0];
    if (q2.size() > 0) d[3*W-1:2*W] = q2[0];
    bus.input_val  = v;
    bus.input_data = d;
  endtask

  task automatic clear_fifos();
    q0.delete();
    q1.delete();
    q2.delete();
    drive();
  endtask

  // One clock: sample acks/handshake before the edge, pop FIFOs after it.
  task automatic tick();
    #1;
    ack_s = bus.input_ack;
    if (bus.out_val && bus.out_rdy) begin
      rx_data.push_back(bus.out_data);
      rx_cam.push_back(int'(bus.out_cam));
      rx_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ack_s[0] && q0.size() > 0) void'(q0.pop_front());
    if (ack_s[1] && q1.size() > 0) void'(q1.pop_front());
    if (ack_s[2] && q2.size() > 0) void'(q2.pop_front());
    if (frame_done) n_done++;
    drive();
  endtask

  int e2c[12] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2, 0, 2};
  int e2k[12] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 3, 4, 4};

  initial begin
    int early;
    int got;
    int done0;
    n_tot = 0; n_bad = 0; cyc = 0; n_done = 0;
    RESET = 1'b1;
    bus.out_rdy = 1'b1;
    clear_fifos();
    tick();
    tick();
    RESET = 1'b0;
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_cam", bus.out_cam, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_error", error, 0);
    check("rst_ack", bus.input_ack, 0);

    // Frame 1: staggered SOF, then plain round robin
    early = 0;
    for (int t = 0; t <= 20; t++) begin
      if (t == 5) begin frame_words(0, 4); frame_words(1, 4); drive(); end
      if (t == 20) begin frame_words(2, 4); drive(); end
      tick();
      if (t >= 5 && t < 20 && ack_s != 3'b000) early++;
      if (t == 19) check("f1_no_early_start", frame_start, 0);
      if (t == 20) begin
        check("f1_align_ack", ack_s, 3'b111);
        check("f1_frame_start", frame_start, 1);
      end
    end
    check("f1_sof_held", early, 0);
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      tick();
      if (frame_done) got = 1;
    end
    check("f1_done_seen", got, 1);
    repeat (3) tick();
    check("f1_done_pulses", n_done, 1);
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_rx_count", rx_data.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < rx_data.size()) begin
        check("f1_rx_cam", rx_cam[i], i % 3);
        check("f1_rx_data", rx_data[i], dw(i % 3, i / 3));
      end
    end
    if (rx_cyc.size() >= 12) check("f1_consecutive", rx_cyc[11] - rx_cyc[0], 11);

    // Frame 2: stall right after the first load, cam 1 ends early with extra words queued
    rx_data.delete(); rx_cam.delete(); rx_cyc.delete();
    done0 = n_done;
    bus.out_rdy = 1'b0;
    frame_words(0, 5);
    push(1, sofw(1)); push(1, dw(1, 0)); push(1, dw(1, 1)); push(1, eofw(1));
    push(1, dw(1, 8)); push(1, dw(1, 9));
    frame_words(2, 5);
    drive();
    tick();
    check("f2_sof_ack", ack_s, 3'b111);
    check("f2_frame_start", frame_start, 1);
    tick();
    check("f2_first_grant", ack_s, 3'b001);
    check("f2_out_val", bus.out_val, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_ack", ack_s, 3'b000);
      check("stall_data", bus.out_data, dw(0, 0));
    end
    bus.out_rdy = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      tick();
      if (frame_done) got = 1;
    end
    check("f2_done_seen", got, 1);
    check("f2_cam1_held", q1.size(), 2);
    repeat (3) tick();
    check("f2_done_pulses", n_done - done0, 1);
    check("f2_frame_cnt", frame_cnt, 2);
    check("f2_interframe_drain", q1.size(), 0);
    check("f2_rx_count", rx_data.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < rx_data.size()) begin
        check("f2_rx_cam", rx_cam[i], e2c[i]);
        check("f2_rx_data", rx_data[i], dw(e2c[i], e2k[i]));
      end
    end

    // SOF on cam 0 mid-frame
    push(0, sofw(0)); push(0, sofw(0));
    push(1, sofw(1)); push(1, dw(1, 5));
    push(2, sofw(2)); push(2, dw(2, 5));
    drive();
    tick();
    check("e1_sof_ack", ack_s, 3'b111);
    tick();
    check("e1_detect_ack", ack_s, 3'b000);
    check("e1_error", error, 1);
    check("e1_out_val", bus.out_val, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("e1_ack_after", ack_s, 3'b000);
    end
    check("e1_sticky", error, 1);
    check("e1_frame_cnt", frame_cnt, 2);

    RESET = 1'b1;
    clear_fifos();
    tick();
    RESET = 1'b0;
    check("e1_rst_error", error, 0);
    check("e1_rst_frame_cnt", frame_cnt, 0);

    // Patch-number boundary: N_PATCH-1 is data, N_PATCH is bad
    push(2, {20'd599999, 20'h00001});
    drive();
    tick();
    check("e2_legal_ack", ack_s, 3'b100);
    check("e2_no_error", error, 0);
    push(2, {20'd600000, 20'h00002});
    drive();
    tick();
    check("e2_bad_ack", ack_s, 3'b000);
    check("e2_error", error, 1);

    RESET = 1'b1;
    clear_fifos();
    tick();
    RESET = 1'b0;
    check("e2_rst_error", error, 0);

    // Only cam 0 shows SOF
    push(0, sofw(0));
    drive();
`ifdef CAM_STREAM_ARB_TIMEOUT_EN
    repeat (100) tick();
    check("wd_before_limit", error, 0);
    tick();
    check("wd_fired", error, 1);
`else
    repeat (1000) tick();
    check("wd_absent", error, 0);
    check("wd_sof_held", ack_s, 3'b000);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
